// File: rtl/data_mem_responder.sv
// Data-side memory responder for the MIPS MEM stage: zero-wait loads, posted stores
// through a forwarding store buffer, an MMIO window and a debug read port on the RAM.
module data_mem_responder #(
    parameter int          ADDR_W   = 10,
    parameter int          SB_DEPTH = 4,
    parameter logic [15:0] MMIO_HI  = 16'hFFFF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               adr_Mem,
    input  logic [31:0]               writeData_Mem,
    input  logic                      memWrite,
    input  logic                      memRead,
    output logic [31:0]               readData_Mem,
    input  logic                      dbg_req,
    input  logic [ADDR_W-1:0]         dbg_addr,
    output logic                      dbg_ack,
    output logic [31:0]               dbg_rdata,
    output logic [31:0]               gpio_out,
    output logic                      misalign_err,
    output logic [$clog2(SB_DEPTH):0] sb_count
);

    localparam int          PW         = $clog2(SB_DEPTH);
    localparam logic [15:0] OFS_CYCLE  = 16'h0000;
    localparam logic [15:0] OFS_GPIO   = 16'h0004;
    localparam logic [15:0] OFS_STATUS = 16'h0008;

    logic [31:0]                    mem_r [0:(2**ADDR_W)-1];
    logic [SB_DEPTH-1:0][ADDR_W-1:0] sb_idx_r;
    logic [SB_DEPTH-1:0][31:0]       sb_data_r;
    logic [PW-1:0]                  head_r;
    logic [PW-1:0]                  tail_r;
    logic [PW:0]                    count_r;
    logic [31:0]                    cycle_r;
    logic [31:0]                    gpio_r;
    logic                           misalign_r;
    logic                           dbg_ack_r;
    logic [31:0]                    dbg_rdata_r;

    logic                           is_mmio_s;
    logic [15:0]                    offset_s;
    logic [ADDR_W-1:0]              ram_idx_s;
    logic                           misaligned_s;
    logic                           bad_access_s;
    logic                           push_s;
    logic                           pop_s;
    logic                           mmio_wr_s;
    logic                           full_s;
    logic                           not_empty_s;
    logic                           dbg_grant_s;
    logic                           w1c_s;
    logic [32:0]                    ld_hit_s;
    logic [32:0]                    dbg_hit_s;
    logic [31:0]                    status_s;

    // Scans oldest to youngest so the last valid match (youngest) wins; returns {hit, data}.
    function automatic logic [32:0] sb_lookup(
        input logic [ADDR_W-1:0]             key,
        input logic [SB_DEPTH-1:0][ADDR_W-1:0] idx,
        input logic [SB_DEPTH-1:0][31:0]     data,
        input logic [PW-1:0]                 head,
        input logic [PW:0]                   count
    );
        logic [32:0]   res;
        logic [PW-1:0] pos;
        res = 33'h0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            pos = head + PW'(i);
            res = (((PW+1)'(i) < count) && (idx[pos] == key)) ? {1'b1, data[pos]} : res;
        end
        return res;
    endfunction

    // Address decode, RAM port arbitration and store-buffer lookups.
    always_comb begin
        is_mmio_s    = (adr_Mem[31:16] == MMIO_HI);
        offset_s     = adr_Mem[15:0];
        ram_idx_s    = adr_Mem[ADDR_W+1:2];
        misaligned_s = (adr_Mem[1:0] != 2'b00);
        bad_access_s = misaligned_s & (memRead | memWrite);
        push_s       = memWrite & ~misaligned_s & ~is_mmio_s;
        mmio_wr_s    = memWrite & ~misaligned_s & is_mmio_s;
        full_s       = (count_r == (PW+1)'(SB_DEPTH));
        not_empty_s  = (count_r != {(PW+1){1'b0}});
        // A full buffer always drains, so a push while full is matched by a pop.
        dbg_grant_s  = dbg_req & ~full_s;
        pop_s        = not_empty_s & ~dbg_grant_s;
        w1c_s        = mmio_wr_s & (offset_s == OFS_STATUS) & writeData_Mem[8];
        ld_hit_s     = sb_lookup(ram_idx_s, sb_idx_r, sb_data_r, head_r, count_r);
        dbg_hit_s    = sb_lookup(dbg_addr, sb_idx_r, sb_data_r, head_r, count_r);
        status_s       = 32'h0;
        status_s[PW:0] = count_r;
        status_s[8]    = misalign_r;
    end

    // Load data mux: MMIO registers, forwarded store data or RAM.
    always_comb begin
        readData_Mem = 32'h0;
        if (memRead && !misaligned_s) begin
            if (is_mmio_s) begin
                case (offset_s)
                    OFS_CYCLE:  readData_Mem = cycle_r;
                    OFS_GPIO:   readData_Mem = gpio_r;
                    OFS_STATUS: readData_Mem = status_s;
                    default:    readData_Mem = 32'h0;
                endcase
            end else begin
                readData_Mem = ld_hit_s[32] ? ld_hit_s[31:0] : mem_r[ram_idx_s];
            end
        end else begin
            readData_Mem = 32'h0;
        end
    end

    // Store-buffer pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {(PW+1){1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                head_r <= head_r + {{(PW-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{PW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{PW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Store-buffer payload; contents are only meaningful below count_r.
    always_ff @(posedge clk) begin
        if (push_s) begin
            sb_idx_r[tail_r]  <= ram_idx_s;
            sb_data_r[tail_r] <= writeData_Mem;
        end
    end

    // RAM write port, fed only by buffer draining.
    always_ff @(posedge clk) begin
        if (pop_s) begin
            mem_r[sb_idx_r[head_r]] <= sb_data_r[head_r];
        end
    end

    // MMIO registers and the sticky misalignment flag (set beats W1C).
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_r    <= 32'h0;
            gpio_r     <= 32'h0;
            misalign_r <= 1'b0;
        end else begin
            cycle_r <= cycle_r + 32'h1;
            if (mmio_wr_s && (offset_s == OFS_GPIO)) begin
                gpio_r <= writeData_Mem;
            end
            if (bad_access_s) begin
                misalign_r <= 1'b1;
            end else if (w1c_s) begin
                misalign_r <= 1'b0;
            end
        end
    end

    // Registered debug read with one-cycle acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_ack_r   <= 1'b0;
            dbg_rdata_r <= 32'h0;
        end else begin
            dbg_ack_r <= dbg_grant_s;
            if (dbg_grant_s) begin
                dbg_rdata_r <= dbg_hit_s[32] ? dbg_hit_s[31:0] : mem_r[dbg_addr];
            end
        end
    end

    assign dbg_ack      = dbg_ack_r;
    assign dbg_rdata    = dbg_rdata_r;
    assign gpio_out     = gpio_r;
    assign misalign_err = misalign_r;
    assign sb_count     = count_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: store buffer, arbitration,
// forwarding, debug port, MMIO window, misalignment and reset behaviour.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr_Mem;
    logic [31:0] writeData_Mem;
    logic        memWrite;
    logic        memRead;
    logic [31:0] readData_Mem;
    logic        dbg_req;
    logic [9:0]  dbg_addr;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic [31:0] gpio_out;
    logic        misalign_err;
    logic [2:0]  sb_count;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] exp_cyc  = 32'h0;

    data_mem_responder dut (
        .clk           (clk),
        .rst           (rst),
        .adr_Mem       (adr_Mem),
        .writeData_Mem (writeData_Mem),
        .memWrite      (memWrite),
        .memRead       (memRead),
        .readData_Mem  (readData_Mem),
        .dbg_req       (dbg_req),
        .dbg_addr      (dbg_addr),
        .dbg_ack       (dbg_ack),
        .dbg_rdata     (dbg_rdata),
        .gpio_out      (gpio_out),
        .misalign_err  (misalign_err),
        .sb_count      (sb_count)
    );

    always #5 clk = ~clk;

    // Reference cycle counter.
    always @(posedge clk) begin
        if (rst) exp_cyc <= 32'h0;
        else     exp_cyc <= exp_cyc + 32'h1;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        memWrite      = 1'b0;
        memRead       = 1'b0;
        adr_Mem       = 32'h0;
        writeData_Mem = 32'h0;
    endtask

    logic [31:0] exp_cnt [6] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd4, 32'd4};
    logic [31:0] exp_ack [6] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 32'd0};

    initial begin
        rst = 1'b1;
        dbg_req = 1'b0;
        dbg_addr = 10'h0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_eq("rst_sb_count", 32'(sb_count), 32'h0);
        chk_eq("rst_gpio", gpio_out, 32'h0);
        chk_eq("rst_misalign", 32'(misalign_err), 32'h0);
        chk_eq("rst_dbg_ack", 32'(dbg_ack), 32'h0);
        chk_eq("rst_dbg_rdata", dbg_rdata, 32'h0);
        memRead = 1'b1; adr_Mem = 32'hFFFF_0000;
        #1;
        chk_eq("rst_cycle", readData_Mem, 32'h0);
        idle_inputs();

        // Single store then load.
        memWrite = 1'b1; adr_Mem = 32'h40; writeData_Mem = 32'h1111_1111;
        tick();
        idle_inputs();
        memRead = 1'b1; adr_Mem = 32'h40;
        #1;
        chk_eq("st1_count1", 32'(sb_count), 32'h1);
        chk_eq("st1_fwd", readData_Mem, 32'h1111_1111);
        tick();
        chk_eq("st1_count0", 32'(sb_count), 32'h0);
        chk_eq("st1_ram", readData_Mem, 32'h1111_1111);
        idle_inputs();

        // Six stores while debug holds the port.
        dbg_req = 1'b1; dbg_addr = 10'h20;
        for (int i = 0; i < 6; i++) begin
            memWrite = 1'b1; adr_Mem = 32'h100 + 32'(4 * i); writeData_Mem = 32'(i);
            tick();
            chk_eq($sformatf("full_count_%0d", i), 32'(sb_count), exp_cnt[i]);
            chk_eq($sformatf("full_ack_%0d", i), 32'(dbg_ack), exp_ack[i]);
        end
        idle_inputs();
        tick();
        chk_eq("full_count_6", 32'(sb_count), 32'h3);
        chk_eq("full_ack_6", 32'(dbg_ack), 32'h0);
        tick();
        chk_eq("full_count_7", 32'(sb_count), 32'h3);
        chk_eq("full_ack_7", 32'(dbg_ack), 32'h1);
        dbg_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            memRead = 1'b1; adr_Mem = 32'h100 + 32'(4 * i);
            #1;
            chk_eq($sformatf("full_load_%0d", i), readData_Mem, 32'(i));
            tick();
        end

        // Load and store together: load sees the pre-store value.
        memRead = 1'b1; memWrite = 1'b1; adr_Mem = 32'h104; writeData_Mem = 32'h5555_5555;
        #1;
        chk_eq("rw_same_cycle", readData_Mem, 32'h1);
        tick();
        memWrite = 1'b0;
        #1;
        chk_eq("rw_next_cycle", readData_Mem, 32'h5555_5555);
        idle_inputs();
        repeat (6) tick();
        chk_eq("drained", 32'(sb_count), 32'h0);

        // Two stores to the same word with draining blocked.
        dbg_req = 1'b1; dbg_addr = 10'h20;
        memWrite = 1'b1; adr_Mem = 32'h80; writeData_Mem = 32'hA;
        tick();
        writeData_Mem = 32'hB;
        tick();
        idle_inputs();
        memRead = 1'b1; adr_Mem = 32'h80;
        #1;
        chk_eq("youngest_fwd", readData_Mem, 32'hB);
        chk_eq("youngest_count", 32'(sb_count), 32'h2);
        dbg_req = 1'b0;
        tick();
        tick();
        chk_eq("youngest_drained", 32'(sb_count), 32'h0);
        chk_eq("youngest_ram", readData_Mem, 32'hB);
        chk_eq("dbg_idle_ack", 32'(dbg_ack), 32'h0);
        idle_inputs();
        dbg_req = 1'b1;
        tick();
        chk_eq("dbg_ack", 32'(dbg_ack), 32'h1);
        chk_eq("dbg_rdata", dbg_rdata, 32'hB);
        dbg_req = 1'b0;
        tick();
        chk_eq("dbg_ack_pulse", 32'(dbg_ack), 32'h0);

        // Misaligned accesses and status W1C.
        memWrite = 1'b1; adr_Mem = 32'h42; writeData_Mem = 32'h77;
        tick();
        chk_eq("mis_no_push", 32'(sb_count), 32'h0);
        chk_eq("mis_flag", 32'(misalign_err), 32'h1);
        idle_inputs();
        memRead = 1'b1; adr_Mem = 32'h42;
        #1;
        chk_eq("mis_load_zero", readData_Mem, 32'h0);
        tick();
        adr_Mem = 32'hFFFF_0008;
        #1;
        chk_eq("status_set", readData_Mem, 32'h100);
        idle_inputs();
        memWrite = 1'b1; adr_Mem = 32'hFFFF_000A; writeData_Mem = 32'h100;
        tick();
        chk_eq("mis_set_wins", 32'(misalign_err), 32'h1);
        adr_Mem = 32'hFFFF_0008;
        tick();
        chk_eq("w1c_clear", 32'(misalign_err), 32'h0);
        idle_inputs();
        memRead = 1'b1; adr_Mem = 32'hFFFF_0008;
        #1;
        chk_eq("status_clear", readData_Mem, 32'h0);
        idle_inputs();

        // MMIO GPIO, cycle counter, unmapped offset.
        memWrite = 1'b1; adr_Mem = 32'hFFFF_0004; writeData_Mem = 32'hDEAD_BEEF;
        tick();
        chk_eq("gpio_out", gpio_out, 32'hDEAD_BEEF);
        chk_eq("mmio_no_push", 32'(sb_count), 32'h0);
        memWrite = 1'b0; memRead = 1'b1;
        #1;
        chk_eq("gpio_read", readData_Mem, 32'hDEAD_BEEF);
        adr_Mem = 32'hFFFF_0000;
        #1;
        chk_eq("cycle_a", readData_Mem, exp_cyc);
        repeat (3) tick();
        chk_eq("cycle_b", readData_Mem, exp_cyc);
        adr_Mem = 32'hFFFF_000C;
        #1;
        chk_eq("mmio_unmapped", readData_Mem, 32'h0);
        memRead = 1'b0; memWrite = 1'b1; writeData_Mem = 32'h1234_5678;
        tick();
        chk_eq("gpio_unmapped_wr", gpio_out, 32'hDEAD_BEEF);
        idle_inputs();

        // Reset discards buffered stores.
        for (int i = 0; i < 3; i++) begin
            memWrite = 1'b1; adr_Mem = 32'h200 + 32'(4 * i); writeData_Mem = 32'h1000 + 32'(i);
            tick();
        end
        idle_inputs();
        repeat (4) tick();
        dbg_req = 1'b1; dbg_addr = 10'h20;
        for (int i = 0; i < 3; i++) begin
            memWrite = 1'b1; adr_Mem = 32'h200 + 32'(4 * i); writeData_Mem = 32'h2000 + 32'(i);
            tick();
        end
        chk_eq("pre_rst_count", 32'(sb_count), 32'h3);
        idle_inputs();
        memRead = 1'b1; adr_Mem = 32'h204;
        #1;
        chk_eq("pre_rst_fwd", readData_Mem, 32'h2001);
        adr_Mem = 32'h201;
        tick();
        chk_eq("pre_rst_mis", 32'(misalign_err), 32'h1);
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0; dbg_req = 1'b0;
        chk_eq("post_rst_count", 32'(sb_count), 32'h0);
        chk_eq("post_rst_gpio", gpio_out, 32'h0);
        chk_eq("post_rst_mis", 32'(misalign_err), 32'h0);
        chk_eq("post_rst_ack", 32'(dbg_ack), 32'h0);
        chk_eq("post_rst_rdata", dbg_rdata, 32'h0);
        memRead = 1'b1; adr_Mem = 32'hFFFF_0000;
        #1;
        chk_eq("post_rst_cycle", readData_Mem, 32'h0);
        for (int i = 0; i < 3; i++) begin
            adr_Mem = 32'h200 + 32'(4 * i);
            #1;
            chk_eq($sformatf("post_rst_old_%0d", i), readData_Mem, 32'h1000 + 32'(i));
            tick();
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
